bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Local-side transaction master for the shared arbitrated parallel bus.
- Accepts one read/write command at a time and requests the bus from the arbiter (barq/bagd).
- Drives address, write data and direction while granted, and completes the transfer on the arbiter's data strobe.
- Returns a response (read data or error) to the local client; one instance per bus master, upstream of the arbiter and bus mux.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- GRANT_TIMEOUT, 16, max cycles in REQ without bagd_i before local error (>=1).
- BUS_TIMEOUT, 32, max cycles in BUS without data_strobe_i/error_i before local error (>=1).

Ports:
- clk  in  1  bus clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  local command valid.
- cmd_ready_o  out  1  block can accept a command.
- cmd_rw_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  AW  command address.
- cmd_wdata_i  in  DW  write data.
- rsp_valid_o  out  1  response valid, held until rsp_ready_i.
- rsp_ready_i  in  1  client accepts response.
- rsp_rdata_o  out  DW  read data; 0 for writes and on error.
- rsp_error_o  out  1  transaction failed.
- barq_o  out  1  bus request to arbiter.
- bagd_i  in  1  bus grant from arbiter.
- addr_o  out  AW  bus address; valid in BUS only.
- data_o  out  DW  bus write data; valid in BUS only.
- rw_o  out  1  bus direction; valid in BUS only.
- data_i  in  DW  bus read data from the selected slave.
- data_strobe_i  in  1  arbiter transfer strobe; completes the transfer.
- error_i  in  1  arbiter error/timeout.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except cmd_ready_o=1; capture registers and counter cleared. Asserting reset mid-transaction drops barq_o immediately; the pending command is discarded and no response is issued.
- States: IDLE, REQ, BUS, RESP. All outputs are registered or decoded from state/registers only; there is no combinational path from bus inputs to bus outputs.
- IDLE:
  - cmd_ready_o=1; all other outputs 0.
  - On cmd_valid_i=1 at an edge: capture rw/addr/wdata, clear counter, go to REQ.
- REQ:
  - barq_o=1; counter increments each cycle.
  - bagd_i=1: go to BUS, clear counter.
  - Otherwise, if counter == GRANT_TIMEOUT-1: go to RESP with error=1.
- BUS:
  - barq_o=1, held for the whole transaction; addr_o/data_o/rw_o = captured values; data_o=0 when rw=0.
  - Priority per edge, highest first:
    1. error_i=1 -> RESP, error=1.
    2. bagd_i=0 (grant lost) -> RESP, error=1.
    3. data_strobe_i=1 -> RESP, error=0; when rw=0, rdata captured from data_i on this edge.
    4. counter == BUS_TIMEOUT-1 -> RESP, error=1.
    5. Otherwise counter increments.
  - Simultaneous data_strobe_i and error_i: error wins, rdata=0.
- RESP:
  - barq_o=0; bus outputs 0; rsp_valid_o=1.
  - rsp_rdata_o/rsp_error_o are stable while rsp_valid_o=1.
  - rsp_ready_i=1: go to IDLE; rsp_valid_o=0 next cycle.
- cmd_ready_o=0 in REQ, BUS and RESP. A command is accepted only in IDLE; no pipelining, max one outstanding transaction.
- Minimum latency, command accept edge = N:
  - barq_o high after N.
  - bagd_i sampled at N+1 -> BUS after N+1.
  - data_strobe_i sampled at N+2 -> rsp_valid_o after N+2.
  - rsp_ready_i=1 at N+3 -> cmd_ready_o=1 after N+3.
- Counter width = clog2(max(GRANT_TIMEOUT, BUS_TIMEOUT)+1); saturating, never wraps.
- bagd_i in IDLE/RESP is ignored. data_strobe_i/error_i outside BUS are ignored.

Test Plan:
1. Write: cmd rw=1 addr=0x0032 wdata=0x0016; bagd_i one cycle after barq_o; data_strobe_i next cycle -> addr_o=0x0032, data_o=0x0016, rw_o=1 during BUS; response error=0, rdata=0; barq_o low in RESP.
2. Read: cmd rw=0 addr=0x002C; data_i=0x01BC when data_strobe_i=1 -> rsp_rdata_o=0x01BC, error=0; data_o=0 during BUS.
3. Grant timeout: GRANT_TIMEOUT=4, bagd_i held 0 -> after exactly 4 REQ cycles, rsp_valid_o=1, error=1, barq_o=0; new command accepted after rsp_ready_i.
4. Arbiter error / simultaneous events: error_i=1 in the same cycle as data_strobe_i=1 on a read -> error=1, rdata=0; repeat with bagd_i dropping mid-BUS -> error=1.
5. Back-pressure and reset: hold rsp_ready_i=0 for 5 cycles -> response stable, cmd_ready_o=0, a second cmd_valid_i is not accepted. Then assert rst_n=0 in BUS -> barq_o=0 immediately, cmd_ready_o=1, rsp_valid_o=0 after release.

Source files
------------

// File: rtl/bus_master_port.sv
// bus_master_port: local-side master for the shared arbitrated parallel bus.
// Takes one read/write command at a time, requests the bus, drives the
// captured address/data/direction while granted, and hands a response
// (read data or error) back to the local client.
module bus_master_port #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int GRANT_TIMEOUT = 16,
  parameter int BUS_TIMEOUT   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // local command side
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_rw_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [DW-1:0] cmd_wdata_i,
  // local response side
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_error_o,
  // arbiter / bus side
  output logic          barq_o,
  input  logic          bagd_i,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          rw_o,
  input  logic [DW-1:0] data_i,
  input  logic          data_strobe_i,
  input  logic          error_i
);

  // One counter serves both the grant wait and the bus wait, so it is sized
  // for the longer of the two limits.
  localparam int MAX_TO = (GRANT_TIMEOUT > BUS_TIMEOUT) ? GRANT_TIMEOUT : BUS_TIMEOUT;
  localparam int CW     = $clog2(MAX_TO + 1);

  localparam logic [CW-1:0] GRANT_LAST = CW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] BUS_LAST   = CW'(BUS_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] BUS  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_inc;

  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          error_q;

  logic          load_cmd;
  logic          load_rsp;
  logic          rsp_err;
  logic          take_rdata;

  // Saturating increment so a long wait can never wrap back to zero.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  // Next state, counter and response outcome; bus-side priority in BUS is
  // error_i, then grant loss, then strobe, then timeout.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_cmd   = 1'b0;
    load_rsp   = 1'b0;
    rsp_err    = 1'b0;
    take_rdata = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          load_cmd  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bagd_i) begin
          cnt_nxt   = '0;
          state_nxt = BUS;
        end else if (cnt == GRANT_LAST) begin
          load_rsp  = 1'b1;
          rsp_err   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      BUS: begin
        if (error_i || !bagd_i) begin
          load_rsp  = 1'b1;
          rsp_err   = 1'b1;
          state_nxt = RESP;
        end else if (data_strobe_i) begin
          load_rsp   = 1'b1;
          take_rdata = ~rw_q;
          state_nxt  = RESP;
        end else if (cnt == BUS_LAST) begin
          load_rsp  = 1'b1;
          rsp_err   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers; reset drops the request straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Command capture on accept; the response fields are cleared here so a
  // stale result can never leak into the next transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (load_cmd) begin
      rw_q    <= cmd_rw_i;
      addr_q  <= cmd_addr_i;
      wdata_q <= cmd_wdata_i;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (load_rsp) begin
      rdata_q <= take_rdata ? data_i : '0;
      error_q <= rsp_err;
    end
  end

  // Outputs decode only from state and registers, never from bus inputs.
  assign cmd_ready_o = (state == IDLE);
  assign barq_o      = (state == REQ) || (state == BUS);
  assign addr_o      = (state == BUS) ? addr_q : '0;
  assign data_o      = ((state == BUS) && rw_q) ? wdata_q : '0;
  assign rw_o        = (state == BUS) ? rw_q : 1'b0;
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = (state == RESP) ? rdata_q : '0;
  assign rsp_error_o = (state == RESP) ? error_q : 1'b0;

endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: directed and randomized transactions against a
// transaction-level model of the bus master port.
module tb_bus_master_port;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int GT = 4;
  localparam int BT = 8;

  localparam int K_STROBE = 0;
  localparam int K_ERROR  = 1;
  localparam int K_BOTH   = 2;
  localparam int K_DROP   = 3;
  localparam int K_NONE   = 4;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_rw_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_error_o;
  logic          barq_o;
  logic          bagd_i;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic          rw_o;
  logic [DW-1:0] data_i;
  logic          data_strobe_i;
  logic          error_i;

  int checks;
  int errors;

  bus_master_port #(
    .AW(AW), .DW(DW), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rw_i(cmd_rw_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .barq_o(barq_o), .bagd_i(bagd_i), .addr_o(addr_o), .data_o(data_o),
    .rw_o(rw_o), .data_i(data_i), .data_strobe_i(data_strobe_i), .error_i(error_i)
  );

  // Free-running bus clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction. The model predicts REQ/BUS durations and the
  // response purely from the timing of the stimulus events.
  task automatic apply_stimulus(input logic rw, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int gdly,
                                input int kind, input int bdly,
                                input logic [DW-1:0] rd, input int hold);
    bit            granted;
    int            exp_req;
    int            exp_bus;
    logic          exp_err;
    logic [DW-1:0] exp_rd;

    granted = (gdly < GT);
    exp_req = granted ? gdly + 1 : GT;
    if (!granted) begin
      exp_bus = 0; exp_err = 1'b1; exp_rd = '0;
    end else if (kind == K_NONE || bdly >= BT) begin
      exp_bus = BT; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_bus = bdly + 1;
      exp_err = (kind != K_STROBE);
      exp_rd  = (kind == K_STROBE && !rw) ? rd : '0;
    end

    // command hand-off
    bagd_i = 1'b0; data_strobe_i = 1'b0; error_i = 1'b0; rsp_ready_i = 1'b0;
    check_output("idle_cmd_ready", cmd_ready_o, 1);
    check_output("idle_barq", barq_o, 0);
    cmd_valid_i = 1'b1; cmd_rw_i = rw; cmd_addr_i = addr; cmd_wdata_i = wdata;
    next_cycle();
    cmd_valid_i = 1'b0;
    cmd_addr_i  = AW'($urandom);
    cmd_wdata_i = DW'($urandom);

    // waiting for grant; strobe/error noise must be ignored here
    for (int i = 0; i < exp_req; i++) begin
      check_output("req_barq", barq_o, 1);
      check_output("req_cmd_ready", cmd_ready_o, 0);
      check_output("req_rsp_valid", rsp_valid_o, 0);
      bagd_i        = granted && (i == gdly);
      data_strobe_i = 1'($urandom);
      error_i       = 1'($urandom);
      data_i        = DW'($urandom);
      next_cycle();
    end

    // granted bus phase
    for (int j = 0; j < exp_bus; j++) begin
      check_output("bus_barq", barq_o, 1);
      check_output("bus_addr", addr_o, addr);
      check_output("bus_data", data_o, rw ? wdata : '0);
      check_output("bus_rw", rw_o, rw);
      check_output("bus_rsp_valid", rsp_valid_o, 0);
      bagd_i        = !(kind == K_DROP && j == bdly);
      data_strobe_i = (kind == K_STROBE || kind == K_BOTH) && (j == bdly);
      error_i       = (kind == K_ERROR || kind == K_BOTH) && (j == bdly);
      data_i        = (j == bdly) ? rd : DW'($urandom);
      next_cycle();
    end

    // response held under back-pressure; a second command must be refused
    for (int h = 0; h <= hold; h++) begin
      check_output("rsp_valid", rsp_valid_o, 1);
      check_output("rsp_error", rsp_error_o, exp_err);
      check_output("rsp_rdata", rsp_rdata_o, exp_rd);
      check_output("rsp_barq", barq_o, 0);
      check_output("rsp_addr", addr_o, 0);
      check_output("rsp_data", data_o, 0);
      check_output("rsp_cmd_ready", cmd_ready_o, 0);
      bagd_i        = 1'($urandom);
      data_strobe_i = 1'($urandom);
      error_i       = 1'($urandom);
      data_i        = DW'($urandom);
      cmd_valid_i   = (h < hold) ? 1'($urandom) : 1'b0;
      rsp_ready_i   = (h == hold);
      next_cycle();
    end
    rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b0;
    check_output("done_rsp_valid", rsp_valid_o, 0);
    check_output("done_cmd_ready", cmd_ready_o, 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_rw_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b0; bagd_i = 1'b0; data_i = '0;
    data_strobe_i = 1'b0; error_i = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check_output("rst_cmd_ready", cmd_ready_o, 1);
    check_output("rst_barq", barq_o, 0);
    check_output("rst_rsp_valid", rsp_valid_o, 0);
    check_output("rst_addr", addr_o, 0);
    check_output("rst_rdata", rsp_rdata_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // write, read, grant timeout, error+strobe, grant loss, bus timeout
    apply_stimulus(1'b1, 16'h0032, 16'h0016, 0, K_STROBE, 0, 16'hAAAA, 0);
    apply_stimulus(1'b0, 16'h002C, 16'h5555, 0, K_STROBE, 0, 16'h01BC, 0);
    apply_stimulus(1'b0, 16'h0010, 16'h0000, GT + 3, K_STROBE, 0, 16'h1234, 0);
    apply_stimulus(1'b0, 16'h0044, 16'h0000, 1, K_BOTH, 2, 16'hBEEF, 1);
    apply_stimulus(1'b1, 16'h0048, 16'h7777, 0, K_DROP, 1, 16'h0000, 0);
    apply_stimulus(1'b0, 16'h0050, 16'h0000, GT - 1, K_NONE, 0, 16'h0000, 0);
    apply_stimulus(1'b0, 16'h0052, 16'h0000, 2, K_STROBE, BT - 1, 16'hC0DE, 5);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      apply_stimulus(1'($urandom), AW'($urandom), DW'($urandom),
                     int'($urandom_range(0, GT + 1)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, BT + 1)), DW'($urandom),
                     int'($urandom_range(0, 3)));
    end

    // reset asserted in the middle of a bus transfer
    cmd_valid_i = 1'b1; cmd_rw_i = 1'b1; cmd_addr_i = 16'h0099; cmd_wdata_i = 16'h4242;
    next_cycle();
    cmd_valid_i = 1'b0; bagd_i = 1'b1;
    next_cycle();
    check_output("mid_bus_barq", barq_o, 1);
    check_output("mid_bus_addr", addr_o, 16'h0099);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_barq", barq_o, 0);
    check_output("async_rst_cmd_ready", cmd_ready_o, 1);
    check_output("async_rst_addr", addr_o, 0);
    @(negedge clk);
    rst_n = 1'b1; bagd_i = 1'b0;
    next_cycle();
    check_output("post_rst_rsp_valid", rsp_valid_o, 0);
    check_output("post_rst_cmd_ready", cmd_ready_o, 1);
    check_output("post_rst_barq", barq_o, 0);

    // recovery after reset
    apply_stimulus(1'b0, 16'h00A0, 16'h0000, 0, K_STROBE, 3, 16'h5A5A, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
